// File: rtl/arith_pkg.sv
// Shared types for the handshaked arithmetic unit: operation codes and FSM states.
package arith_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/arith_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH cycles from start
// to the done pulse; the first partial product is folded into the start cycle.
module arith_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy     <= 1'b1;
                product  <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                mcand_q  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                mplier_q <= b >> 1;
                count_q  <= CW'(1);
            end else if (busy) begin
                if (mplier_q[0]) begin
                    product <= product + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q + CW'(1);
                if (count_q == CW'(WIDTH-1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/arith_pipe_unit.sv
// Handshaked ALU with sequential multiplier and carry/overflow/zero flags.
// Optional unsigned result saturation is compiled in with macro ARITH_SAT_EN.
module arith_pipe_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [2:0]       op_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             carry,
    output logic             ovf,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

`ifdef ARITH_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_e state_q, state_d;
    op_e    op_in;
    logic   accept;
    logic   mul_start, mul_busy, mul_done;

    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_carry;

    logic [WIDTH:0]     add_ext, sub_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry, alu_ovf;

    assign op_in     = op_e'(op_sel);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op_in == OP_MUL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (op_in == OP_MUL) ? MUL : HOLD;
                end
            end
            MUL: begin
                if (mul_done && !mul_busy) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = (op_in == OP_MUL) ? MUL : HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign add_ext = {1'b0, data_1} + {1'b0, data_2};
    assign sub_ext = {1'b0, data_1} - {1'b0, data_2};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op_in)
            OP_ADD: begin
                alu_res   = add_ext[WIDTH-1:0];
                alu_carry = add_ext[WIDTH];
                alu_ovf   = (data_1[WIDTH-1] == data_2[WIDTH-1]) &&
                            (add_ext[WIDTH-1] != data_1[WIDTH-1]);
                if (SAT_EN && alu_carry) alu_res = '1;
            end
            OP_SUB: begin
                alu_res   = sub_ext[WIDTH-1:0];
                alu_carry = sub_ext[WIDTH];
                alu_ovf   = (data_1[WIDTH-1] != data_2[WIDTH-1]) &&
                            (sub_ext[WIDTH-1] != data_1[WIDTH-1]);
                if (SAT_EN && alu_carry) alu_res = '0;
            end
            OP_AND:  alu_res = data_1 & data_2;
            OP_OR:   alu_res = data_1 | data_2;
            OP_XOR:  alu_res = data_1 ^ data_2;
            OP_SHL:  alu_res = data_1 << data_2[SHW-1:0];
            OP_SHR:  alu_res = data_1 >> data_2[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    arith_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (data_1),
        .b       (data_2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign mul_carry = |mul_product[2*WIDTH-1:WIDTH];
    assign mul_res   = (SAT_EN && mul_carry) ? '1 : mul_product[WIDTH-1:0];

    // Result registers only load on a new result, which keeps them frozen under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            carry    <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else if (accept && (op_in != OP_MUL)) begin
            data_out <= alu_res;
            carry    <= alu_carry;
            ovf      <= alu_ovf;
            zero     <= (alu_res == '0);
        end else if ((state_q == MUL) && mul_done) begin
            data_out <= mul_res;
            carry    <= mul_carry;
            ovf      <= 1'b0;
            zero     <= (mul_res == '0);
        end
    end

endmodule

// File: tb/tb_arith_pipe_unit.sv
// Directed bench for arith_pipe_unit (WIDTH=16) with a result scoreboard;
// expectations follow ARITH_SAT_EN when it is defined.
module tb_arith_pipe_unit;

    typedef struct {
        logic [15:0] data;
        logic        carry;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_1;
    logic [15:0] data_2;
    logic [2:0]  op_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
    logic        carry;
    logic        ovf;
    logic        zero;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   accept_cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    arith_pipe_unit #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_1    (data_1),
        .data_2    (data_2),
        .op_sel    (op_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        int     s;
        int     sa;
        int     sb_v;
        longint p;
        e.data = 16'h0; e.carry = 1'b0; e.ovf = 1'b0;
        sa   = $signed(a);
        sb_v = $signed(b);
        case (op)
            3'd0: begin
                s = int'(a) + int'(b);
                e.data  = s[15:0];
                e.carry = (s > 65535);
                e.ovf   = ((sa + sb_v) > 32767) || ((sa + sb_v) < -32768);
`ifdef ARITH_SAT_EN
                if (e.carry) e.data = 16'hFFFF;
`endif
            end
            3'd1: begin
                s = int'(a) - int'(b);
                e.data  = s[15:0];
                e.carry = (a < b);
                e.ovf   = ((sa - sb_v) > 32767) || ((sa - sb_v) < -32768);
`ifdef ARITH_SAT_EN
                if (e.carry) e.data = 16'h0000;
`endif
            end
            3'd2: begin
                p = longint'(a) * longint'(b);
                e.data  = p[15:0];
                e.carry = (p > 65535);
`ifdef ARITH_SAT_EN
                if (e.carry) e.data = 16'hFFFF;
`endif
            end
            3'd3: e.data = a & b;
            3'd4: e.data = a | b;
            3'd5: e.data = a ^ b;
            3'd6: e.data = a << b[3:0];
            default: e.data = a >> b[3:0];
        endcase
        e.zero = (e.data == 16'h0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op, wait for acceptance, push its expected result, then drop in_valid.
    task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        op_sel = op; data_1 = a; data_2 = b; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        sb.push_back(model(op, a, b));
        accept_cyc = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int lat);
        int n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, cyc - accept_cyc, lat);
    endtask

    // Scoreboard: compare every retired result against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_data",  data_out, mon_e.data);
                check("sb_carry", carry,    mon_e.carry);
                check("sb_ovf",   ovf,      mon_e.ovf);
                check("sb_zero",  zero,     mon_e.zero);
            end
        end
    end

    initial begin
        logic [2:0]  tbl_op [4];
        logic [15:0] tbl_a  [4];
        logic [15:0] tbl_b  [4];
        logic [15:0] held;
        logic        stable;
        logic        stalled;
        logic        seen;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        data_1 = 16'h0; data_2 = 16'h0; op_sel = 3'd0;
        repeat (3) tick();
        check("rst_data_out",  data_out,  32'd0);
        check("rst_carry",     carry,     32'd0);
        check("rst_ovf",       ovf,       32'd0);
        check("rst_zero",      zero,      32'd0);
        check("rst_out_valid", out_valid, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 32'd1);

        out_ready = 1'b1;
        drive(3'd0, 16'd10, 16'd20);
        wait_out("add_10_20", 1);
        check("add_10_20_data", data_out, 32'd30);
        tick();

        drive(3'd1, 16'd30, 16'd40);
        wait_out("sub_30_40", 1);
        tick();
        drive(3'd0, 16'h7FFF, 16'h0001);
        wait_out("add_7fff_1", 1);
        tick();
        drive(3'd0, 16'hFFFF, 16'h0001);
        wait_out("add_ffff_1", 1);
        tick();

        drive(3'd2, 16'd300, 16'd300);
        check("mul_busy_in_ready", in_ready, 32'd0);
        wait_out("mul_300_300", 17);
        tick();

        tbl_op[0] = 3'd3; tbl_a[0] = 16'hF0F0; tbl_b[0] = 16'h3C3C;
        tbl_op[1] = 3'd4; tbl_a[1] = 16'h00F0; tbl_b[1] = 16'h0F00;
        tbl_op[2] = 3'd7; tbl_a[2] = 16'h8000; tbl_b[2] = 16'h000F;
        tbl_op[3] = 3'd5; tbl_a[3] = 16'h1234; tbl_b[3] = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            drive(tbl_op[i], tbl_a[i], tbl_b[i]);
            wait_out("logic_op", 1);
        end
        tick();

        // Backpressure on an XOR result with a SHL waiting behind it.
        out_ready = 1'b0;
        drive(3'd5, 16'hA5A5, 16'h0F0F);
        wait_out("xor_bp", 1);
        held = data_out;
        op_sel = 3'd6; data_1 = 16'h0001; data_2 = 16'h0004; in_valid = 1'b1;
        stable = 1'b1; stalled = 1'b1;
        repeat (5) begin
            if (data_out !== held || out_valid !== 1'b1) stable = 1'b0;
            if (in_ready !== 1'b0) stalled = 1'b0;
            tick();
        end
        check("bp_data_stable", stable, 32'd1);
        check("bp_in_ready_low", stalled, 32'd1);
        check("bp_xor_data", held, 32'h0000AAAA);
        out_ready = 1'b1;
        sb.push_back(model(3'd6, 16'h0001, 16'h0004));
        accept_cyc = cyc;
        tick();
        in_valid = 1'b0;
        check("b2b_shl_valid", out_valid, 32'd1);
        check("b2b_shl_data", data_out, 32'h00000010);
        tick();

        // Reset five cycles into a multiply must abort it silently.
        drive(3'd2, 16'd300, 16'd300);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        sb.delete();
        check("abort_data_out",  data_out,  32'd0);
        check("abort_carry",     carry,     32'd0);
        check("abort_zero",      zero,      32'd0);
        check("abort_out_valid", out_valid, 32'd0);
        reset = 1'b0;
        tick();
        check("abort_in_ready", in_ready, 32'd1);
        seen = 1'b0;
        repeat (20) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("abort_no_result", seen, 32'd0);

        drive(3'd0, 16'h0001, 16'h0002);
        wait_out("add_after_abort", 1);
        repeat (3) tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arith_pipe_unit.md
# arith_pipe_unit

Parametrised, handshaked arithmetic/logic unit for the datapath, replacing the fixed 16-bit, free-running `arithunit`. It adds a WIDTH parameter, an 8-operation set, a multi-cycle sequential multiplier, and result flags. Operands enter on a valid/ready input channel and results leave on a valid/ready output channel, so the unit sits directly between operand buffers and a result consumer.

## Interface
- `WIDTH`, default 16: operand and result width; legal values are ≥ 2.
- `SHW`, localparam `$clog2(WIDTH)`: shift-amount width.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operand and op are presented.
- `in_ready`, output, 1: unit accepts this cycle.
- `data_1`, input, WIDTH: operand A.
- `data_2`, input, WIDTH: operand B; `data_2[SHW-1:0]` is the shift amount.
- `op_sel`, input, 3: operation code.
- `out_valid`, output, 1: result and flags are valid.
- `out_ready`, input, 1: consumer takes the result.
- `data_out`, output, WIDTH: registered result.
- `carry`, output, 1: carry, borrow or multiply-overflow flag.
- `ovf`, output, 1: signed overflow flag (ADD/SUB only).
- `zero`, output, 1: `data_out == 0`.

## Operation
- op codes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 MUL: low WIDTH bits of A×B, unsigned.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SHL: A << B[SHW-1:0], zero fill.
  - 7 SHR: A >> B[SHW-1:0], logical.
- A transfer occurs when `in_valid && in_ready`. Operands and op are captured at that edge; later input changes have no effect on the operation in flight.
- FSM states:
  - IDLE: `in_ready=1`, `out_valid=0`.
    - Accept of a non-MUL op → HOLD.
    - Accept of MUL → MUL.
  - MUL: shift-add, one partial product per cycle, WIDTH cycles; `in_ready=0`, `out_valid=0`. → HOLD after the last step.
  - HOLD: `out_valid=1`; result and flags are held stable.
    - `out_ready=0`: stay in HOLD; `in_ready=0`.
    - `out_ready=1`, `in_valid=0`: → IDLE.
    - `out_ready=1`, `in_valid=1`: result retires and the new op is accepted at the same edge (`in_ready = out_ready` in HOLD). Next state is HOLD (non-MUL) or MUL.
- Flags:
  - ADD: `carry` = carry-out.
  - SUB: `carry` = borrow (A < B, unsigned).
  - MUL: `carry` = 1 iff the upper WIDTH bits of the full product are nonzero.
  - Logic ops and shifts: `carry=0`.
  - `ovf`: two's-complement overflow for ADD/SUB; 0 for every other op.
  - `zero` is computed from the final `data_out`, after saturation when that option is compiled in.
- Arithmetic is computed at WIDTH+1 bits for ADD/SUB and 2·WIDTH bits for the MUL accumulator; results are truncated to WIDTH.

## Timing
- Reset values: state IDLE, `data_out=0`, `carry=0`, `ovf=0`, `zero=0`, `out_valid=0`. `in_ready` is 1 in the cycle after reset is released.
- Non-MUL latency: `out_valid` rises at the first edge after acceptance (1 cycle).
- MUL latency: `out_valid` rises WIDTH+1 edges after acceptance.
- Throughput:
  - Non-MUL ops sustain one op per cycle while `out_ready=1`.
  - MUL ops sustain one op per WIDTH+1 cycles.
- While `out_valid=1 && out_ready=0`, `data_out` and the flags must not change.
- Reset asserted in any state, including mid-MUL, aborts the operation. No result is produced, and all outputs take their reset values at that edge.
- `in_valid` is ignored while `in_ready=0`; no input queueing.

## Configuration
- Macro `ARITH_SAT_EN`.
- Defined: unsigned saturation of the result.
  - ADD with carry → all ones.
  - SUB with borrow → 0.
  - MUL with `carry` set → all ones.
  - `carry`/`ovf` still report the unsaturated condition.
- Undefined: results wrap modulo 2^WIDTH.

## Structure
- Package `arith_pkg` holds:
  - `op_e` enum with the 8 op codes (3 bits).
  - `state_e` enum {IDLE, MUL, HOLD}.
- Sub-module `arith_mul_seq` holds the shift-add multiplier.
  - Interface: start, operands, busy, done, 2·WIDTH product.
  - The top module owns the FSM, the ALU ops, the flags and saturation.

## Test plan
All scenarios use WIDTH=16.
- ADD 10+20, `out_ready=1` → `data_out=30` exactly 1 cycle after accept; `carry=ovf=zero=0`.
- SUB 30−40 → `0xFFF6`, `carry=1`, `ovf=0`. With `ARITH_SAT_EN` → `0x0000`, `carry=1`, `zero=1`.
- ADD `0x7FFF`+1 → `0x8000`, `ovf=1`, `carry=0`. ADD `0xFFFF`+1 → `0x0000`, `carry=1`, `zero=1`.
- MUL 300×300 → `0x5F90`, `carry=1`, `out_valid` 17 cycles after accept. With `ARITH_SAT_EN` → `0xFFFF`.
- Backpressure:
  - Hold `out_ready=0` for 5 cycles on a valid XOR result → `data_out` stable and `in_ready=0` throughout.
  - Then raise `out_ready` with a queued SHL `0x0001`<<4 → `0x0010` on the next cycle, back-to-back.
- Reset asserted 5 cycles into a MUL → `out_valid` never rises for that op, all outputs 0, `in_ready=1` after release.
